// File: rtl/bp_iteration_scheduler.sv
// Iteration sequencer for a belief-propagation LDPC decoder.
// Steps column, row and syndrome phases with a per-phase watchdog.
module bp_iteration_scheduler #(
    parameter int ITER_W  = 6,
    parameter int TMO_W   = 10,
    parameter int TMO_MAX = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ITER_W-1:0] max_iter,
    output logic              clr,
    output logic              col_start,
    input  logic              col_done,
    output logic              row_start,
    input  logic              row_done,
    output logic              syn_start,
    input  logic              syn_done,
    input  logic              syn_zero,
    output logic              busy,
    output logic              done,
    output logic              converged,
    output logic              timeout,
    output logic [ITER_W-1:0] iter_count
);

    typedef enum logic [3:0] {
        S_IDLE, S_CLR, S_COL_GO, S_COL_WT, S_ROW_GO,
        S_ROW_WT, S_SYN_GO, S_SYN_WT, S_FIN
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ITER_W-1:0] lim;
    logic [ITER_W-1:0] iter_inc;
    logic [TMO_W-1:0]  wd;
    logic              wd_exp;
    logic              last_iter;
    logic              aborting;

    assign wd_exp    = (wd == TMO_W'(TMO_MAX - 1));
    assign iter_inc  = iter_count + ITER_W'(1);
    assign last_iter = (iter_inc == lim);
    assign aborting  = abort && (state != S_IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state selection; abort overrides every other transition
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   if (start) state_nx = S_CLR;
            S_CLR:    state_nx = S_COL_GO;
            S_COL_GO: state_nx = S_COL_WT;
            S_COL_WT: begin
                if (col_done)    state_nx = S_ROW_GO;
                else if (wd_exp) state_nx = S_FIN;
            end
            S_ROW_GO: state_nx = S_ROW_WT;
            S_ROW_WT: begin
                if (row_done)    state_nx = S_SYN_GO;
                else if (wd_exp) state_nx = S_FIN;
            end
            S_SYN_GO: state_nx = S_SYN_WT;
            S_SYN_WT: begin
                if (syn_done) begin
                    if (syn_zero || last_iter) state_nx = S_FIN;
                    else                       state_nx = S_COL_GO;
                end else if (wd_exp) begin
                    state_nx = S_FIN;
                end
            end
            S_FIN:    state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
        if (aborting) state_nx = S_IDLE;
    end

    // Strobes and busy/done decoded from the state register only
    always_comb begin
        clr       = (state == S_CLR);
        col_start = (state == S_COL_GO);
        row_start = (state == S_ROW_GO);
        syn_start = (state == S_SYN_GO);
        done      = (state == S_FIN);
        busy      = (state != S_IDLE);
    end

    // Limit latch, iteration counter, watchdog and result status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lim        <= '0;
            iter_count <= '0;
            wd         <= '0;
            converged  <= 1'b0;
            timeout    <= 1'b0;
        end else if (!aborting) begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        lim        <= (max_iter == '0) ? ITER_W'(1) : max_iter;
                        iter_count <= '0;
                        converged  <= 1'b0;
                        timeout    <= 1'b0;
                    end
                end
                S_COL_GO, S_ROW_GO, S_SYN_GO: wd <= '0;
                S_COL_WT: begin
                    if (!col_done) begin
                        if (wd_exp) timeout <= 1'b1;
                        else        wd      <= wd + TMO_W'(1);
                    end
                end
                S_ROW_WT: begin
                    if (!row_done) begin
                        if (wd_exp) timeout <= 1'b1;
                        else        wd      <= wd + TMO_W'(1);
                    end
                end
                S_SYN_WT: begin
                    if (syn_done) begin
                        iter_count <= iter_inc;
                        if (syn_zero) converged <= 1'b1;
                    end else if (wd_exp) begin
                        timeout <= 1'b1;
                    end else begin
                        wd <= wd + TMO_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/bp_iteration_scheduler.md
BP_ITERATION_SCHEDULER -- requirements
Module: bp_iteration_scheduler

Interface
REQ-001 SHALL have parameter ITER_W, default 6, width of the iteration count and limit.
REQ-002 SHALL have parameter TMO_W, default 10, width of the per-phase watchdog counter.
REQ-003 SHALL have parameter TMO_MAX, default 1000, maximum cycles allowed in any wait state.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, request to decode one codeword.
REQ-007 SHALL have port abort, input, 1, synchronous cancel of the current decode.
REQ-008 SHALL have port max_iter, input, ITER_W, iteration limit, sampled when start is accepted.
REQ-009 SHALL have port clr, output, 1, clear-accumulators strobe to the column-sum and row datapaths.
REQ-010 SHALL have port col_start and col_done, output and input, 1 each, column-sum (variable-node) phase handshake.
REQ-011 SHALL have port row_start and row_done, output and input, 1 each, check-node phase handshake.
REQ-012 SHALL have port syn_start, syn_done and syn_zero, output, input and input, 1 each, syndrome-check handshake; syn_zero is valid with syn_done.
REQ-013 SHALL have port busy, output, 1, high from start acceptance until the cycle done is asserted, inclusive.
REQ-014 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-015 SHALL have ports converged and timeout, output, 1 each, result status.
REQ-016 SHALL have port iter_count, output, ITER_W, number of completed iterations.

Function
REQ-017 SHALL implement states IDLE, CLR, COL_GO, COL_WT, ROW_GO, ROW_WT, SYN_GO, SYN_WT and FIN.
REQ-018 SHALL drive all outputs from registers or decode them from the state register only, with no combinational path from inputs to outputs.
REQ-019 SHALL, in IDLE with start=1, latch max_iter (value 0 treated as 1), clear iter_count, converged and timeout, and enter CLR.
REQ-020 SHALL assert clr for exactly one cycle in CLR, then enter COL_GO.
REQ-021 SHALL assert col_start, row_start and syn_start for exactly one cycle in COL_GO, ROW_GO and SYN_GO respectively; each GO state always advances to its WT state.
REQ-022 SHALL ignore a done input that is high during its GO state and sample each done input only in the matching WT state.
REQ-023 SHALL leave COL_WT for ROW_GO on col_done=1, and leave ROW_WT for SYN_GO on row_done=1.
REQ-024 SHALL, in SYN_WT with syn_done=1, increment iter_count by 1.
REQ-025 SHALL then set converged=1 and enter FIN if syn_zero=1.
REQ-026 SHALL otherwise enter FIN with converged=0 if the incremented count equals the latched limit.
REQ-027 SHALL otherwise enter COL_GO without asserting clr.
REQ-028 SHALL never let iter_count wrap, since the limit is at most 2^ITER_W-1.
REQ-029 SHALL reset the watchdog to 0 on entry to each WT state, increment it by 1 per cycle in the WT state, and on reaching TMO_MAX set timeout=1 and enter FIN.
REQ-030 SHALL give a done input priority over the watchdog when both occur in the same cycle.
REQ-031 SHALL assert done for one cycle in FIN, then return to IDLE.
REQ-032 SHALL hold converged, timeout and iter_count until the next accepted start.
REQ-033 SHALL, on abort=1 in any non-IDLE state, enter IDLE on the next edge with no done pulse, clr/start strobes low and status unchanged; abort has priority over every other transition.
REQ-034 SHALL ignore start while not in IDLE, and SHALL accept start=1 in the same cycle as done on the following IDLE cycle.

Reset
REQ-035 SHALL, on rst_n=0, immediately enter IDLE and force clr, col_start, row_start, syn_start, busy, done, converged and timeout to 0 and iter_count and the watchdog to 0, including mid-decode.
REQ-036 SHALL leave IDLE only on a clk edge after rst_n has returned high and start=1 is sampled.

Verification
REQ-037 SHALL cover early convergence: max_iter=5, done inputs returned 3 cycles after each start, syn_zero=1 on the 2nd syndrome -> done pulse, converged=1, iter_count=2, clr asserted once.
REQ-038 SHALL cover the iteration limit: max_iter=4, syn_zero always 0 -> exactly 4 col/row/syn start pulses each, done with converged=0, timeout=0, iter_count=4.
REQ-039 SHALL cover a watchdog expiry: TMO_MAX=8, row_done never asserted -> timeout=1 and done exactly 8 cycles after ROW_WT entry; with row_done arriving on cycle 8, timeout=0 and decoding proceeds.
REQ-040 SHALL cover abort and reset mid-operation: abort in COL_WT -> IDLE next cycle with no done; rst_n low in SYN_WT -> all outputs 0 asynchronously, and a new start decodes normally.
REQ-041 SHALL cover corner inputs: max_iter=0 -> one iteration then done; col_done held high during COL_GO -> ignored; start during busy -> ignored; start in the cycle after done -> new decode accepted.
